// File: rtl/cache_tester.sv
// Cache tester: writes an address-derived pattern to WORD_COUNT consecutive
// words starting at START_ADDR, reads them back, and counts mismatches.
// Each access that fails to complete within TIMEOUT wait cycles also counts
// as one error.
//
// Ports:
//   sys_clk, sys_rst_n   - clock (rising edge), async active-low reset
//   start                - level; launches a run from idle, or re-launches
//                          from done after it has been seen low
//   address, data_in     - access address and write data to the cache
//   write_enable         - byte enables, 4'b1111 for one cycle per write, 0 = read
//   data_out, data_out_ready, busy - read data, its qualifier, cache stall
//   done, pass           - run finished / finished with no errors
//   error_count          - saturating mismatch+timeout count
//   first_fail_addr      - address of first failing access of the run (0 if none)
//   led                  - active-low status: {busy, done, pass, state[2:0]}
module cache_tester #(
  parameter logic [31:0] START_ADDR = 32'h0000_0000,
  parameter int unsigned WORD_COUNT = 64,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic [3:0]  write_enable,
  input  logic [31:0] data_out,
  input  logic        data_out_ready,
  input  logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  error_count,
  output logic [31:0] first_fail_addr,
  output logic [5:0]  led
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StWrite     = 3'd1;
  localparam logic [2:0] StWriteWait = 3'd2;
  localparam logic [2:0] StRead      = 3'd3;
  localparam logic [2:0] StReadWait  = 3'd4;
  localparam logic [2:0] StDone      = 3'd5;

  // Wait counter runs 0..TIMEOUT-1; the last value ends the access.
  localparam int unsigned      WaitW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [15:0]      LastIdx  = 16'(WORD_COUNT - 1);

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  logic [2:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [15:0]      idx_q, idx_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [7:0]       err_q, err_d;
  logic [31:0]      ffa_q, ffa_d;
  logic             fail_seen_q, fail_seen_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  // Set once start is seen low in done; a later high level restarts.
  logic             armed_q, armed_d;

  logic load, rec_err, adv;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    err_d       = err_q;
    ffa_d       = ffa_q;
    fail_seen_d = fail_seen_q;
    done_d      = done_q;
    pass_d      = pass_q;
    armed_d     = armed_q;
    load        = 1'b0;
    rec_err     = 1'b0;
    adv         = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !busy) load = 1'b1;
      end
      StWrite: begin
        state_d = StWriteWait;
        wait_d  = '0;
      end
      StWriteWait: begin
        if (!busy) begin
          adv = 1'b1;
        end else if (wait_q == WaitLast) begin
          rec_err = 1'b1;
          adv     = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StRead: begin
        state_d = StReadWait;
        wait_d  = '0;
      end
      StReadWait: begin
        // A completion in the timeout cycle still counts as a completion.
        if (data_out_ready && !busy) begin
          rec_err = (data_out != pattern(addr_q));
          adv     = 1'b1;
        end else if (wait_q == WaitLast) begin
          rec_err = 1'b1;
          adv     = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDone: begin
        if (!start) begin
          armed_d = 1'b1;
        end else if (armed_q && !busy) begin
          load = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rec_err) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (!fail_seen_q) begin
        ffa_d       = addr_q;
        fail_seen_d = 1'b1;
      end
    end

    if (adv) begin
      if (idx_q == LastIdx) begin
        if (state_q == StWriteWait) begin
          state_d = StRead;
          idx_d   = '0;
          addr_d  = START_ADDR;
        end else begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end
      end else begin
        idx_d   = idx_q + 16'd1;
        addr_d  = addr_q + 32'd4;
        state_d = (state_q == StWriteWait) ? StWrite : StRead;
      end
    end

    if (load) begin
      state_d     = StWrite;
      addr_d      = START_ADDR;
      idx_d       = '0;
      wait_d      = '0;
      err_d       = '0;
      ffa_d       = '0;
      fail_seen_d = 1'b0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
      armed_d     = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      idx_q       <= '0;
      wait_q      <= '0;
      err_q       <= '0;
      ffa_q       <= '0;
      fail_seen_q <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      ffa_q       <= ffa_d;
      fail_seen_q <= fail_seen_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      armed_q     <= armed_d;
    end
  end

  assign address         = addr_q;
  assign write_enable    = (state_q == StWrite) ? 4'b1111 : 4'b0000;
  // Write data is held through the wait so a stalled cache still sees it.
  assign data_in         = (state_q == StWrite || state_q == StWriteWait) ? pattern(addr_q)
                                                                          : 32'd0;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = err_q;
  assign first_fail_addr = ffa_q;
  // The busy LED is forced dark during reset so all LEDs read 1.
  assign led             = {~(busy & sys_rst_n), ~done_q, ~pass_q, ~state_q};

endmodule

// File: tb/tb_cache_tester.sv
// Bench for cache_tester: two instances (4 words / timeout 15 at address 0,
// and 300 words wrapping past the top of the address space) share one
// behavioural cache model selected by sel.
module tb_cache_tester;

  localparam logic [31:0] SmallStart   = 32'h0000_0000;
  localparam int          SmallWords   = 4;
  localparam int          SmallTimeout = 15;
  localparam logic [31:0] BigStart     = 32'hFFFF_FE00;
  localparam int          BigWords     = 300;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic start     = 1'b0;
  logic sel       = 1'b0;

  always #5 sys_clk = ~sys_clk;

  logic [31:0] s_address, s_data_in, s_ffa, b_address, b_data_in, b_ffa;
  logic [3:0]  s_we, b_we;
  logic        s_done, s_pass, b_done, b_pass;
  logic [7:0]  s_err, b_err;
  logic [5:0]  s_led, b_led;
  logic        s_start, b_start;
  logic [31:0] data_out;
  logic        data_out_ready, busy;

  assign s_start = start & ~sel;
  assign b_start = start & sel;

  cache_tester #(
    .START_ADDR(SmallStart),
    .WORD_COUNT(SmallWords),
    .TIMEOUT   (SmallTimeout)
  ) u_small (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .start          (s_start),
    .address        (s_address),
    .data_in        (s_data_in),
    .write_enable   (s_we),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .busy           (busy),
    .done           (s_done),
    .pass           (s_pass),
    .error_count    (s_err),
    .first_fail_addr(s_ffa),
    .led            (s_led)
  );

  cache_tester #(
    .START_ADDR(BigStart),
    .WORD_COUNT(BigWords)
  ) u_big (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .start          (b_start),
    .address        (b_address),
    .data_in        (b_data_in),
    .write_enable   (b_we),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .busy           (busy),
    .done           (b_done),
    .pass           (b_pass),
    .error_count    (b_err),
    .first_fail_addr(b_ffa),
    .led            (b_led)
  );

  logic [31:0] m_addr, m_din, m_ffa;
  logic [3:0]  m_we;
  logic        m_done, m_pass;
  logic [7:0]  m_err;
  logic [5:0]  m_led;

  assign m_addr = sel ? b_address : s_address;
  assign m_din  = sel ? b_data_in : s_data_in;
  assign m_we   = sel ? b_we      : s_we;
  assign m_done = sel ? b_done    : s_done;
  assign m_pass = sel ? b_pass    : s_pass;
  assign m_err  = sel ? b_err     : s_err;
  assign m_ffa  = sel ? b_ffa     : s_ffa;
  assign m_led  = sel ? b_led     : s_led;

  // Cache model controls, driven only by the initial block.
  int          busy_hold    = 0;
  logic        corrupt_en   = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;
  logic        corrupt_all  = 1'b0;
  logic        nr_en        = 1'b0;
  logic [31:0] nr_addr      = 32'h0;

  // Cache model state and write log, written only by the model process.
  logic [31:0] mem [1024];
  int          busy_cnt = 0;
  logic        rd_valid = 1'b0;
  logic [31:0] rd_addr  = 32'h0;
  logic [31:0] rd_data  = 32'h0;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [3:0]  wr_be   [$];

  always @(posedge sys_clk) begin
    if (m_we != 4'h0) begin
      mem[m_addr[11:2]] <= m_din;
      wr_addr.push_back(m_addr);
      wr_data.push_back(m_din);
      wr_be.push_back(m_we);
      busy_cnt <= busy_hold;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    rd_valid <= (m_we == 4'h0);
    rd_addr  <= m_addr;
    rd_data  <= mem[m_addr[11:2]];
  end

  assign busy           = (busy_cnt != 0);
  assign data_out_ready = rd_valid && (rd_addr == m_addr) && !(nr_en && m_addr == nr_addr);
  assign data_out       = rd_data ^ ((corrupt_all || (corrupt_en && rd_addr == corrupt_addr))
                                     ? 32'h1 : 32'h0);

  int errors = 0;
  int checks = 0;

  // Reference: which words of a run must fail, from the model's fault settings.
  function automatic void ref_run(input int n, input logic [31:0] base,
                                  output int exp_err, output logic [31:0] exp_ffa);
    logic [31:0] a;
    bit          have;
    exp_err = 0;
    exp_ffa = 32'h0;
    have    = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      if (corrupt_all || (corrupt_en && a == corrupt_addr) || (nr_en && a == nr_addr)) begin
        if (!have) begin
          exp_ffa = a;
          have    = 1'b1;
        end
        if (exp_err < 255) exp_err++;
      end
    end
  endfunction

  task automatic clear_faults();
    busy_hold   = 0;
    corrupt_en  = 1'b0;
    corrupt_all = 1'b0;
    nr_en       = 1'b0;
  endtask

  task automatic run_check(input string name, input int n, input logic [31:0] base,
                           input int budget, output int cycles, output int base_idx);
    int          e_err;
    logic [31:0] e_ffa;
    logic [31:0] a;
    logic        e_pass;
    base_idx = wr_addr.size();
    ref_run(n, base, e_err, e_ffa);
    e_pass = (e_err == 0);
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    cycles = 0;
    while (m_done !== 1'b1 && cycles < budget) begin
      @(negedge sys_clk);
      cycles++;
    end
    checks++;
    if (m_done !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got %b want 1 within %0d cycles", name, m_done, budget);
    end
    checks++;
    if (m_pass !== e_pass) begin
      errors++;
      $display("FAIL %s pass: got %b want %b", name, m_pass, e_pass);
    end
    checks++;
    if (m_err !== 8'(e_err)) begin
      errors++;
      $display("FAIL %s error_count: got %0d want %0d", name, m_err, e_err);
    end
    checks++;
    if (m_ffa !== e_ffa) begin
      errors++;
      $display("FAIL %s first_fail_addr: got %h want %h", name, m_ffa, e_ffa);
    end
    checks++;
    if (wr_addr.size() - base_idx != n) begin
      errors++;
      $display("FAIL %s write count: got %0d want %0d", name, wr_addr.size() - base_idx, n);
    end else begin
      for (int i = 0; i < n; i++) begin
        a = base + 32'(4 * i);
        checks++;
        if (wr_addr[base_idx+i] !== a || wr_data[base_idx+i] !== {a[15:0], ~a[15:0]} ||
            wr_be[base_idx+i] !== 4'hF) begin
          errors++;
          $display("FAIL %s write %0d: got %h/%h/%b want %h/%h/1111", name, i,
                   wr_addr[base_idx+i], wr_data[base_idx+i], wr_be[base_idx+i],
                   a, {a[15:0], ~a[15:0]});
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (m_addr !== 32'h0 || m_din !== 32'h0 || m_we !== 4'h0) begin
      errors++;
      $display("FAIL %s access outputs: got addr=%h data=%h we=%b want 0/0/0",
               name, m_addr, m_din, m_we);
    end
    checks++;
    if (m_done !== 1'b0 || m_pass !== 1'b0) begin
      errors++;
      $display("FAIL %s done/pass: got %b/%b want 0/0", name, m_done, m_pass);
    end
    checks++;
    if (m_err !== 8'h0 || m_ffa !== 32'h0) begin
      errors++;
      $display("FAIL %s err/ffa: got %0d/%h want 0/0", name, m_err, m_ffa);
    end
    checks++;
    if (m_led !== 6'b111111) begin
      errors++;
      $display("FAIL %s led: got %b want 111111", name, m_led);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    sel = 1'b0;
    #1 check_reset_outputs("reset_small");
    sel = 1'b1;
    #1 check_reset_outputs("reset_big");
    sel = 1'b0;
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_ideal();
    int          cyc, bidx;
    logic [31:0] exp4 [4];
    exp4[0] = 32'h0000FFFF;
    exp4[1] = 32'h0004FFFB;
    exp4[2] = 32'h0008FFF7;
    exp4[3] = 32'h000CFFF3;
    clear_faults();
    sel = 1'b0;
    run_check("ideal", SmallWords, SmallStart, 500, cyc, bidx);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wr_addr.size() < bidx + 4 || wr_data[bidx+i] !== exp4[i]) begin
        errors++;
        $display("FAIL ideal literal data %0d: got %h want %h", i, wr_data[bidx+i], exp4[i]);
      end
    end
    checks++;
    if (cyc != 4 * SmallWords) begin
      errors++;
      $display("FAIL ideal latency: got %0d cycles want %0d", cyc, 4 * SmallWords);
    end
    repeat (5) @(negedge sys_clk);
    checks++;
    if (m_done !== 1'b1 || m_pass !== 1'b1 || m_led[4:3] !== 2'b00) begin
      errors++;
      $display("FAIL ideal hold: got done=%b pass=%b led=%b want 1/1/x00xxx",
               m_done, m_pass, m_led);
    end
  endtask

  task automatic test_corrupt();
    int cyc, bidx;
    clear_faults();
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h8;
    run_check("corrupt8", SmallWords, SmallStart, 500, cyc, bidx);
  endtask

  task automatic test_timeout();
    int cyc, bidx;
    clear_faults();
    nr_en   = 1'b1;
    nr_addr = 32'h4;
    run_check("timeout4", SmallWords, SmallStart, 500, cyc, bidx);
    checks++;
    if (cyc != 4 * SmallWords + SmallTimeout - 1) begin
      errors++;
      $display("FAIL timeout4 latency: got %0d cycles want %0d", cyc,
               4 * SmallWords + SmallTimeout - 1);
    end
  endtask

  task automatic test_random();
    int cyc, bidx;
    for (int it = 0; it < 4; it++) begin
      clear_faults();
      busy_hold    = int'($urandom_range(0, 10));
      corrupt_en   = 1'($urandom_range(0, 1));
      corrupt_addr = 32'(4 * $urandom_range(0, 3));
      run_check("random", SmallWords, SmallStart, 1000, cyc, bidx);
    end
  endtask

  task automatic test_busy();
    int cyc, bidx;
    clear_faults();
    sel       = 1'b1;
    busy_hold = 20;
    run_check("busy20", BigWords, BigStart, 20000, cyc, bidx);
    busy_hold = 0;
  endtask

  task automatic test_saturate();
    int cyc, bidx;
    clear_faults();
    sel         = 1'b1;
    corrupt_all = 1'b1;
    run_check("saturate", BigWords, BigStart, 5000, cyc, bidx);
    corrupt_all = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int n, bidx, cyc;
    clear_faults();
    sel          = 1'b0;
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h4;
    @(negedge sys_clk) start = 1'b1;
    @(negedge sys_clk) start = 1'b0;
    n = 0;
    while (m_err !== 8'd1 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    while (m_led[2:0] !== 3'b011 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    checks++;
    if (m_led[2:0] !== 3'b011 || m_err !== 8'd1 || m_ffa !== 32'h4) begin
      errors++;
      $display("FAIL midrun setup: got led=%b err=%0d ffa=%h want xxx011/1/4",
               m_led, m_err, m_ffa);
    end
    sys_rst_n = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    @(negedge sys_clk) sys_rst_n = 1'b1;
    clear_faults();
    bidx = wr_addr.size();
    n    = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (m_we !== 4'h0 || m_led[2:0] !== 3'b111) n++;
    end
    checks++;
    if (n != 0 || wr_addr.size() != bidx) begin
      errors++;
      $display("FAIL midrun idle: got %0d active cycles, %0d writes want 0/0",
               n, wr_addr.size() - bidx);
    end
    run_check("midrun_rerun", SmallWords, SmallStart, 500, cyc, bidx);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_corrupt();
    test_timeout();
    test_random();
    test_busy();
    test_saturate();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
